multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  MEM_TIMEOUT, 15, max cycles waiting for mem_ready before fault; 0 disables watchdog
  RET_W, 32, width of retired-instruction counter
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  opcode  in  5  inst[6:2] of the instruction register
  mem_ready  in  1  memory completes current request this cycle
  branch_taken  in  1  branch comparator result, valid in EXECUTE
  mem_req  out  1  memory access request
  mem_we  out  1  store request
  mem_is_instr  out  1  address mux selects PC
  ir_write  out  1  load instruction register
  pc_write  out  1  update PC
  pc_src  out  2  0=PC+4, 1=branch/JAL target, 2=JALR target
  reg_write  out  1  register-file write enable
  alu_src_1  out  1  1=PC as ALU operand A
  alu_src_2  out  1  1=immediate as ALU operand B
  alu_op  out  2  0=ADD, 1=SUB, 2=RTYPE, 3=ITYPE
  mem_to_reg  out  2  0=ALU, 1=DM, 2=PC+4, 3=IMM
  state  out  3  current state encoding
  halted  out  1  core stopped
  fault  out  1  memory watchdog expired
  retired  out  RET_W  instructions completed

Function
REQ-003 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5; codes 6-7 go to HALT.
REQ-004 Legal opcodes: R 01100, I 00100, LOAD 00000, STORE 01000, BRANCH 11000, JALR 11001, JAL 11011, LUI 01101, AUIPC 00101; all others illegal.
REQ-005 All outputs SHALL be Moore/registered-state functions; default 0 in every state unless stated.
REQ-006 FETCH: mem_req=1, mem_is_instr=1; on mem_ready, ir_write=1 same cycle, next DECODE; else remain.
REQ-007 DECODE: one cycle; illegal opcode -> HALT, else EXECUTE.
REQ-008 EXECUTE: one cycle; alu_src/alu_op per opcode: R(0,0,RTYPE), I(0,1,ITYPE), LOAD/STORE/JALR/LUI(0,1,ADD), BRANCH(0,0,SUB), JAL/AUIPC(1,1,ADD).
REQ-009 EXECUTE exit: LOAD/STORE -> MEM; BRANCH -> FETCH with pc_write=1, pc_src=branch_taken?1:0; all others -> WB.
REQ-010 MEM: mem_req=1, mem_we=1 for STORE; alu control held as EXECUTE; wait for mem_ready; LOAD -> WB; STORE -> FETCH with pc_write=1, pc_src=0.
REQ-011 WB: reg_write=1, pc_write=1, mem_to_reg DM(LOAD), PC+4(JAL/JALR), IMM(LUI), ALU otherwise; pc_src 1 for JAL, 2 for JALR, else 0; next FETCH.
REQ-012 retired SHALL increment by 1 on every cycle with pc_write=1, wrapping modulo 2^RET_W.
REQ-013 Watchdog counter, width clog2(MEM_TIMEOUT+1), clears on entering FETCH/MEM and on mem_ready; counts each waiting cycle; reaching MEM_TIMEOUT without mem_ready -> HALT, fault=1.
REQ-014 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-015 HALT: halted=1, all strobes 0, fault and retired frozen; exits only via reset.

Reset
REQ-016 rst low SHALL immediately force state=FETCH, retired=0, fault=0, watchdog=0, independent of clk, including mid-MEM access (mem_req drops asynchronously).
REQ-017 First FETCH request SHALL appear in the first cycle after rst deasserts.

Verification
REQ-018 R-type, mem_ready=1 in FETCH -> FETCH,DECODE,EXECUTE,WB; WB shows reg_write=1, pc_write=1, pc_src=0; retired=1.
REQ-019 LOAD with mem_ready delayed 3 cycles in MEM -> 3 MEM stall cycles, then WB mem_to_reg=1; total 8 cycles with 1-cycle fetch.
REQ-020 BRANCH taken -> EXECUTE pc_write=1, pc_src=1, no WB; not-taken -> pc_src=0.
REQ-021 JALR -> EXECUTE alu_src_2=1 alu_op=0; WB mem_to_reg=2, pc_src=2.
REQ-022 opcode 11100 (ECALL) -> HALT after DECODE, halted=1, fault=0, retired unchanged; mem_ready withheld 15 cycles in FETCH -> HALT with fault=1.
REQ-023 rst pulse during MEM of STORE -> mem_we drops without clk edge; restart in FETCH, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multicycle RV32I-style core. Walks each instruction
// through FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB], drives the datapath
// strobes and mux selects from the current state and opcode, counts
// retired instructions, and halts on an illegal opcode or when memory fails
// to answer within MEM_TIMEOUT waiting cycles.
//
// Ports
//   clk, rst          clock (rising edge), async active-low reset
//   opcode            inst[6:2] of the instruction register
//   mem_ready         memory completes the current request this cycle
//   branch_taken      branch comparator result, used in EXECUTE
//   mem_req/mem_we    memory request / store request
//   mem_is_instr      address mux selects PC
//   ir_write          load instruction register
//   pc_write, pc_src  PC update and source (0=PC+4, 1=br/JAL, 2=JALR)
//   reg_write         register-file write enable
//   alu_src_1/2       1=PC as operand A / 1=immediate as operand B
//   alu_op            0=ADD 1=SUB 2=RTYPE 3=ITYPE
//   mem_to_reg        0=ALU 1=DM 2=PC+4 3=IMM
//   state             current state encoding
//   halted, fault     core stopped / memory watchdog expired
//   retired           instructions completed (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_instr,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             alu_src_1,
    output logic             alu_src_2,
    output logic [1:0]       alu_op,
    output logic [1:0]       mem_to_reg,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam int              WD_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (MEM_TIMEOUT > 0) ? WD_W'(MEM_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    state_t            r_state, w_next;
    logic              r_fault;
    logic [WD_W-1:0]   r_wd;
    logic [RET_W-1:0]  r_retired;

    logic w_r, w_i, w_ld, w_st, w_br, w_jalr, w_jal, w_lui, w_auipc, w_legal;
    logic w_wait, w_tmo;
    logic w_src1, w_src2;
    logic [1:0] w_aluop;

    assign w_r     = (opcode == OP_R);
    assign w_i     = (opcode == OP_I);
    assign w_ld    = (opcode == OP_LOAD);
    assign w_st    = (opcode == OP_STORE);
    assign w_br    = (opcode == OP_BRANCH);
    assign w_jalr  = (opcode == OP_JALR);
    assign w_jal   = (opcode == OP_JAL);
    assign w_lui   = (opcode == OP_LUI);
    assign w_auipc = (opcode == OP_AUIPC);
    assign w_legal = w_r | w_i | w_ld | w_st | w_br | w_jalr | w_jal | w_lui | w_auipc;

    // A waiting cycle is any FETCH/MEM cycle without mem_ready; the watchdog
    // fires on the MEM_TIMEOUT-th consecutive one.
    assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
    assign w_tmo  = (MEM_TIMEOUT > 0) && w_wait && (r_wd == WD_LAST);

    // ALU control, shared by EXECUTE and MEM (address calc held during access)
    always_comb begin
        w_src1  = 1'b0;
        w_src2  = 1'b0;
        w_aluop = 2'd0;
        if (w_r) begin
            w_aluop = 2'd2;
        end else if (w_i) begin
            w_src2  = 1'b1;
            w_aluop = 2'd3;
        end else if (w_br) begin
            w_aluop = 2'd1;
        end else if (w_jal || w_auipc) begin
            w_src1 = 1'b1;
            w_src2 = 1'b1;
        end else if (w_ld || w_st || w_jalr || w_lui) begin
            w_src2 = 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_instr = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        reg_write    = 1'b0;
        alu_src_1    = 1'b0;
        alu_src_2    = 1'b0;
        alu_op       = 2'd0;
        mem_to_reg   = 2'd0;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_is_instr = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_tmo) begin
                    w_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                w_next = w_legal ? ST_EXECUTE : ST_HALT;
            end
            ST_EXECUTE: begin
                alu_src_1 = w_src1;
                alu_src_2 = w_src2;
                alu_op    = w_aluop;
                if (w_ld || w_st) begin
                    w_next = ST_MEM;
                end else if (w_br) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? 2'd1 : 2'd0;
                    w_next   = ST_FETCH;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = w_st;
                alu_src_1 = w_src1;
                alu_src_2 = w_src2;
                alu_op    = w_aluop;
                if (mem_ready) begin
                    if (w_st) begin
                        pc_write = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_tmo) begin
                    w_next = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (w_ld)                mem_to_reg = 2'd1;
                else if (w_jal || w_jalr) mem_to_reg = 2'd2;
                else if (w_lui)          mem_to_reg = 2'd3;
                if (w_jal)       pc_src = 2'd1;
                else if (w_jalr) pc_src = 2'd2;
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_HALT;
            end
        endcase
        // Strobes are killed combinationally while reset is held so an
        // in-flight memory access is withdrawn without waiting for a clock.
        if (!rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_is_instr = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            reg_write    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_FETCH;
            r_fault   <= 1'b0;
            r_wd      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_tmo)   r_fault   <= 1'b1;
            if (w_wait)  r_wd      <= r_wd + 1'b1;
            else         r_wd      <= '0;
            if (pc_write) r_retired <= r_retired + 1'b1;
        end
    end

    assign state   = r_state;
    assign fault   = r_fault;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench. Each instruction is described at instruction level
// (opcode, fetch wait, memory wait, branch outcome); the model expands it
// into the per-cycle output record the control unit must show, and a
// single negedge process checks every queued record against the DUT.
// Literal checks pin retired counts, cycle counts and reset/fault values.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int TMO = 15;

    localparam logic [4:0] R_OP  = 5'b01100;
    localparam logic [4:0] I_OP  = 5'b00100;
    localparam logic [4:0] LD_OP = 5'b00000;
    localparam logic [4:0] ST_OP = 5'b01000;
    localparam logic [4:0] BR_OP = 5'b11000;
    localparam logic [4:0] JR_OP = 5'b11001;
    localparam logic [4:0] JL_OP = 5'b11011;
    localparam logic [4:0] LU_OP = 5'b01101;
    localparam logic [4:0] AU_OP = 5'b00101;
    localparam logic [4:0] EC_OP = 5'b11100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  opcode = 5'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_we, mem_is_instr, ir_write, pc_write, reg_write;
    logic        alu_src_1, alu_src_2, halted, fault;
    logic [1:0]  pc_src, alu_op, mem_to_reg;
    logic [2:0]  state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .RET_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .mem_is_instr(mem_is_instr), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .alu_src_1(alu_src_1),
        .alu_src_2(alu_src_2), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .state(state), .halted(halted), .fault(fault), .retired(retired)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        mem_req, mem_we, mem_is_instr, ir_write, pc_write;
        logic [1:0]  pc_src;
        logic        reg_write, alu_src_1, alu_src_2;
        logic [1:0]  alu_op, mem_to_reg;
        logic        halted, fault;
        logic [31:0] retired;
    } exp_t;

    exp_t expq[$];
    int   nvec = 0, nerr = 0, ncyc = 0, mdl_ret = 0;
    bit   mdl_fault = 1'b0, mdl_halt = 1'b0;

    function automatic exp_t base(input logic [2:0] st);
        exp_t e = '0;
        e.state   = st;
        e.halted  = (st == 3'd5);
        e.fault   = mdl_fault;
        e.retired = 32'(mdl_ret);
        return e;
    endfunction

    // {alu_src_1, alu_src_2, alu_op} from the opcode table
    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            R_OP:                      return 4'b00_10;
            I_OP:                      return 4'b01_11;
            BR_OP:                     return 4'b00_01;
            JL_OP, AU_OP:              return 4'b11_00;
            default:                   return 4'b01_00;
        endcase
    endfunction

    function automatic bit legal(input logic [4:0] op);
        return op inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP, JR_OP, JL_OP, LU_OP, AU_OP};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        exp_t a, e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            a.state = state; a.mem_req = mem_req; a.mem_we = mem_we;
            a.mem_is_instr = mem_is_instr; a.ir_write = ir_write;
            a.pc_write = pc_write; a.pc_src = pc_src; a.reg_write = reg_write;
            a.alu_src_1 = alu_src_1; a.alu_src_2 = alu_src_2; a.alu_op = alu_op;
            a.mem_to_reg = mem_to_reg; a.halted = halted; a.fault = fault;
            a.retired = retired;
            nvec++;
            if (a !== e) begin
                nerr++;
                $display("FAIL cycle t=%0t act=%h exp=%h", $time, a, e);
            end
        end
    end

    task automatic step(input logic rdy, input exp_t e);
        mem_ready = rdy;
        expq.push_back(e);
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic do_fetch(input int fw);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            e = base(3'd0); e.mem_req = 1'b1; e.mem_is_instr = 1'b1;
            step(1'b0, e);
            if (i + 1 == TMO) begin mdl_fault = 1'b1; mdl_halt = 1'b1; return; end
        end
        e = base(3'd0); e.mem_req = 1'b1; e.mem_is_instr = 1'b1; e.ir_write = 1'b1;
        step(1'b1, e);
    endtask

    task automatic do_decode(input logic [4:0] op);
        exp_t e = base(3'd1);
        step(1'b1, e);
        if (!legal(op)) mdl_halt = 1'b1;
    endtask

    task automatic do_execute(input logic [4:0] op, input logic bt);
        exp_t e = base(3'd2);
        {e.alu_src_1, e.alu_src_2, e.alu_op} = alu_of(op);
        if (op == BR_OP) begin e.pc_write = 1'b1; e.pc_src = bt ? 2'd1 : 2'd0; end
        step(1'b1, e);
        if (op == BR_OP) mdl_ret++;
    endtask

    task automatic do_mem(input logic [4:0] op, input int mw);
        exp_t e;
        for (int i = 0; i < mw; i++) begin
            e = base(3'd3); e.mem_req = 1'b1; e.mem_we = (op == ST_OP);
            {e.alu_src_1, e.alu_src_2, e.alu_op} = alu_of(op);
            step(1'b0, e);
            if (i + 1 == TMO) begin mdl_fault = 1'b1; mdl_halt = 1'b1; return; end
        end
        e = base(3'd3); e.mem_req = 1'b1; e.mem_we = (op == ST_OP);
        {e.alu_src_1, e.alu_src_2, e.alu_op} = alu_of(op);
        e.pc_write = (op == ST_OP);
        step(1'b1, e);
        if (op == ST_OP) mdl_ret++;
    endtask

    task automatic do_wb(input logic [4:0] op);
        exp_t e = base(3'd4);
        e.reg_write = 1'b1; e.pc_write = 1'b1;
        e.mem_to_reg = (op == LD_OP) ? 2'd1 : (op == JL_OP || op == JR_OP) ? 2'd2 :
                       (op == LU_OP) ? 2'd3 : 2'd0;
        e.pc_src = (op == JL_OP) ? 2'd1 : (op == JR_OP) ? 2'd2 : 2'd0;
        step(1'b1, e);
        mdl_ret++;
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++) step(logic'(i % 2 == 0), base(3'd5));
    endtask

    task automatic exec(input logic [4:0] op, input int fw, input int mw, input logic bt);
        opcode = op; branch_taken = bt;
        do_fetch(fw);          if (mdl_halt) return;
        do_decode(op);         if (mdl_halt) return;
        do_execute(op, bt);    if (op == BR_OP) return;
        if (op == LD_OP || op == ST_OP) begin
            do_mem(op, mw);    if (mdl_halt || op == ST_OP) return;
        end
        do_wb(op);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_retired", retired,      32'd0);
        chk("rst_fault",   32'(fault),   32'd0);
        chk("rst_halted",  32'(halted),  32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        mdl_ret = 0; mdl_fault = 1'b0; mdl_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int c0;
        #2;
        do_reset();

        c0 = ncyc; exec(R_OP, 0, 0, 1'b0);
        chk("r_cycles",  32'(ncyc - c0), 32'd4);
        chk("r_retired", retired,        32'd1);
        c0 = ncyc; exec(LD_OP, 0, 3, 1'b0);
        chk("ld_cycles", 32'(ncyc - c0), 32'd8);
        exec(I_OP,  2, 0, 1'b1);
        exec(ST_OP, 0, 1, 1'b0);
        c0 = ncyc; exec(BR_OP, 0, 0, 1'b1);
        chk("br_cycles", 32'(ncyc - c0), 32'd3);
        exec(BR_OP, 1, 0, 1'b0);
        exec(JR_OP, 0, 0, 1'b0);
        exec(JL_OP, 0, 0, 1'b1);
        exec(LU_OP, 0, 0, 1'b0);
        exec(AU_OP, 0, 0, 1'b0);
        exec(R_OP, TMO - 1, 0, 1'b0);
        chk("retired_11", retired, 32'd11);

        // illegal opcode: halt without fault, counters frozen
        exec(EC_OP, 0, 0, 1'b0);
        do_halt(3);
        chk("ecall_halted",  32'(halted), 32'd1);
        chk("ecall_fault",   32'(fault),  32'd0);
        chk("ecall_retired", retired,     32'd11);

        // reset in the middle of a store's memory access
        do_reset();
        exec(R_OP, 0, 0, 1'b0);
        opcode = ST_OP; branch_taken = 1'b0;
        do_fetch(0); do_decode(ST_OP); do_execute(ST_OP, 1'b0);
        mem_ready = 1'b0;
        #2;
        chk("st_mem_we_pre", 32'(mem_we),  32'd1);
        chk("st_retired_pre", retired,     32'd1);
        rst = 1'b0;
        #1;
        chk("st_mem_we_rst",  32'(mem_we),  32'd0);
        chk("st_mem_req_rst", 32'(mem_req), 32'd0);
        chk("st_state_rst",   32'(state),   32'd0);
        chk("st_retired_rst", retired,      32'd0);
        mdl_ret = 0; mdl_fault = 1'b0; mdl_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // fetch watchdog
        exec(R_OP, TMO, 0, 1'b0);
        do_halt(3);
        chk("wd_fault",   32'(fault),  32'd1);
        chk("wd_halted",  32'(halted), 32'd1);
        chk("wd_retired", retired,     32'd0);

        do_reset();
        exec(JL_OP, 0, 0, 1'b0);
        chk("post_retired", retired, 32'd1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL bench_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
